// File: rtl/fifo_sync_pkg.sv
// fifo_sync_pkg: shared sizing helpers and default constants for the fifo_sync slice.
package fifo_sync_pkg;
    localparam int DEF_DEPTH       = 64;
    localparam int DEF_BYTE_WIDTH  = 8;
    localparam int DEF_COUNT_WIDTH = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // One extra MSB lets equal low bits mean either full or empty after a wrap.
    function automatic int ptr_w(input int depth);
        return clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fifo_sync_if.sv
// fifo_sync_if: write/read handshake bundle; master drives requests, slave is the FIFO.
interface fifo_sync_if #(
    parameter int DW = 64,
    parameter int CW = 8
);
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          wr_full;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_empty;
    logic [CW-1:0] data_count;

    modport master (
        output wr_en, wr_data, rd_en,
        input  wr_ack, wr_full, rd_data, rd_valid, rd_empty, data_count
    );
    modport slave (
        input  wr_en, wr_data, rd_en,
        output wr_ack, wr_full, rd_data, rd_valid, rd_empty, data_count
    );
endinterface

// File: rtl/fifo_sync_ram.sv
// fifo_sync_ram: simple dual-port RAM, one write port and one registered read port.
module fifo_sync_ram
    import fifo_sync_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int DW    = DEF_BYTE_WIDTH * 8,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (!rstn) rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FIFO with standard or first-word-fall-through output.
// Define FIFO_DATA_ZERO_EN to force rd_data to zero whenever rd_valid is low.
module fifo_sync
    import fifo_sync_pkg::*;
#(
    parameter int FIFO_DEPTH  = DEF_DEPTH,
    parameter int BYTE_WIDTH  = DEF_BYTE_WIDTH,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int FWFT        = 0
) (
    input logic        clk,
    input logic        rstn,
    fifo_sync_if.slave bus
);
    localparam int AW = clog2(FIFO_DEPTH);
    localparam int PW = ptr_w(FIFO_DEPTH);
    localparam int DW = BYTE_WIDTH * 8;

    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   full_q, full_d, empty_q, empty_d, valid_q, valid_d, ack_q;
    logic                   wr_acc, pop, fetch;
    logic [DW-1:0]          ram_q;

    // In FWFT mode the RAM read register doubles as the prefetch register:
    // it is refilled whenever it is empty or being popped and the RAM holds words.
    always_comb begin
        wr_acc   = bus.wr_en & ~full_q;
        pop      = bus.rd_en & ((FWFT != 0) ? valid_q : ~empty_q);
        fetch    = (FWFT != 0) ? (wr_ptr_q != rd_ptr_q) & (~valid_q | bus.rd_en) : pop;
        valid_d  = (FWFT != 0) ? (fetch | (valid_q & ~pop)) : pop;
        wr_ptr_d = wr_ptr_q + PW'(wr_acc);
        rd_ptr_d = rd_ptr_q + PW'(fetch);
        count_d  = count_q + COUNT_WIDTH'(wr_acc) - COUNT_WIDTH'(pop);
        full_d   = count_d == COUNT_WIDTH'(FIFO_DEPTH);
        empty_d  = count_d == '0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            valid_q  <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            valid_q  <= valid_d;
            ack_q    <= wr_acc;
        end
    end

    fifo_sync_ram #(.DEPTH(FIFO_DEPTH), .DW(DW)) u_ram (
        .clk    (clk),
        .rstn   (rstn),
        .we_i   (wr_acc),
        .waddr_i(wr_ptr_q[AW-1:0]),
        .wdata_i(bus.wr_data),
        .re_i   (fetch),
        .raddr_i(rd_ptr_q[AW-1:0]),
        .rdata_o(ram_q)
    );

    assign bus.wr_ack     = ack_q;
    assign bus.wr_full    = full_q;
    assign bus.rd_valid   = valid_q;
    assign bus.rd_empty   = (FWFT != 0) ? ~valid_q : empty_q;
    assign bus.data_count = count_q;
`ifdef FIFO_DATA_ZERO_EN
    assign bus.rd_data    = valid_q ? ram_q : '0;
`else
    assign bus.rd_data    = ram_q;
`endif
endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync: standard and FWFT instances driven in lockstep, checked against queue-based models.
module tb_fifo_sync;
    localparam int DEPTH = 64;
    localparam int DW    = 64;
`ifdef FIFO_DATA_ZERO_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    typedef struct {
        bit          we;
        bit          re;
        logic [63:0] d;
        bit          ack;
        bit          valid;
        logic [63:0] data;
        int          cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic wr_en = 1'b0, rd_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    always #5 clk = ~clk;

    fifo_sync_if #(.DW(DW), .CW(8)) s_if ();
    fifo_sync_if #(.DW(DW), .CW(8)) f_if ();
    assign s_if.wr_en = wr_en;
    assign s_if.rd_en = rd_en;
    assign s_if.wr_data = wr_data;
    assign f_if.wr_en = wr_en;
    assign f_if.rd_en = rd_en;
    assign f_if.wr_data = wr_data;

    fifo_sync #(.FIFO_DEPTH(DEPTH), .BYTE_WIDTH(8), .COUNT_WIDTH(8), .FWFT(0)) u_std (
        .clk(clk), .rstn(rstn), .bus(s_if.slave));
    fifo_sync #(.FIFO_DEPTH(DEPTH), .BYTE_WIDTH(8), .COUNT_WIDTH(8), .FWFT(1)) u_fwft (
        .clk(clk), .rstn(rstn), .bus(f_if.slave));

    logic [63:0] sq[$], fq[$], sent[$], got[$];
    logic [63:0] s_data = '0, f_data = '0;
    bit s_valid, s_ack, f_pres, f_ack;
    int n_chk = 0, n_fail = 0;

    function automatic logic [63:0] shown(bit v, logic [63:0] d);
        return (v || !ZERO) ? d : 64'h0;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Standard model: a read takes the oldest word and shows it for one cycle.
    // FWFT model: the oldest word already stored before an edge is presented after it.
    task automatic model(bit we, bit re, logic [63:0] d);
        bit rok, sw, fw;
        if (!rstn) begin
            sq.delete(); fq.delete();
            s_data = '0; f_data = '0;
            s_valid = 0; s_ack = 0; f_pres = 0; f_ack = 0;
        end else begin
            rok = re && sq.size() != 0;
            sw = we && sq.size() != DEPTH;
            s_valid = rok;
            if (rok) s_data = sq.pop_front();
            s_ack = sw;
            if (sw) sq.push_back(d);
            fw = we && fq.size() != DEPTH;
            if (re && f_pres) begin
                void'(fq.pop_front());
                f_pres = 0;
            end
            if (!f_pres && fq.size() != 0) begin
                f_pres = 1;
                f_data = fq[0];
            end
            f_ack = fw;
            if (fw) fq.push_back(d);
        end
    endtask

    task automatic compare();
        chk("std count", 64'(s_if.data_count), 64'(sq.size()));
        chk("std full", 64'(s_if.wr_full), 64'(sq.size() == DEPTH));
        chk("std empty", 64'(s_if.rd_empty), 64'(sq.size() == 0));
        chk("std ack", 64'(s_if.wr_ack), 64'(s_ack));
        chk("std valid", 64'(s_if.rd_valid), 64'(s_valid));
        chk("std data", s_if.rd_data, shown(s_valid, s_data));
        chk("fwft count", 64'(f_if.data_count), 64'(fq.size()));
        chk("fwft full", 64'(f_if.wr_full), 64'(fq.size() == DEPTH));
        chk("fwft empty", 64'(f_if.rd_empty), 64'(!f_pres));
        chk("fwft ack", 64'(f_if.wr_ack), 64'(f_ack));
        chk("fwft valid", 64'(f_if.rd_valid), 64'(f_pres));
        chk("fwft data", f_if.rd_data, shown(f_pres, f_data));
    endtask

    task automatic step(bit we, bit re, logic [63:0] d);
        wr_en = we; rd_en = re; wr_data = d;
        @(posedge clk);
        model(we, re, d);
        #1;
        compare();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (3) step(1, 1, 64'hDEAD);
        rstn = 1'b1;
    endtask

    initial begin
        vec_t vt[6];
        int cyc;
        vt[0] = '{1, 0, 64'h0123456789ABCDEF, 1, 0, 64'h0, 1};
        vt[1] = '{0, 1, 64'h0, 0, 1, 64'h0123456789ABCDEF, 0};
        vt[2] = '{0, 0, 64'h0, 0, 0, 64'h0123456789ABCDEF, 0};
        vt[3] = '{1, 1, 64'h55, 1, 0, 64'h0123456789ABCDEF, 1};
        vt[4] = '{1, 1, 64'h66, 1, 1, 64'h55, 1};
        vt[5] = '{0, 1, 64'h0, 0, 1, 64'h66, 0};

        do_reset();
        chk("reset empty", 64'(s_if.rd_empty), 64'h1);
        chk("reset full", 64'(s_if.wr_full), 64'h0);
        chk("reset count", 64'(s_if.data_count), 64'h0);
        chk("reset valid", 64'(s_if.rd_valid), 64'h0);
        chk("reset ack", 64'(s_if.wr_ack), 64'h0);
        chk("reset data", s_if.rd_data, 64'h0);

        for (int i = 0; i < 6; i++) begin
            step(vt[i].we, vt[i].re, vt[i].d);
            chk($sformatf("vec%0d ack", i), 64'(s_if.wr_ack), 64'(vt[i].ack));
            chk($sformatf("vec%0d valid", i), 64'(s_if.rd_valid), 64'(vt[i].valid));
            chk($sformatf("vec%0d data", i), s_if.rd_data, shown(vt[i].valid, vt[i].data));
            chk($sformatf("vec%0d count", i), 64'(s_if.data_count), 64'(vt[i].cnt));
        end

        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 0, 64'(i));
        chk("fill full", 64'(s_if.wr_full), 64'h1);
        chk("fill count", 64'(s_if.data_count), 64'd64);
        step(1, 0, 64'hFF);
        chk("overflow ack", 64'(s_if.wr_ack), 64'h0);
        chk("overflow count", 64'(s_if.data_count), 64'd64);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 64'h0);
            chk($sformatf("drain %0d", i), s_if.rd_data, 64'(i));
        end
        step(0, 1, 64'h0);
        chk("drained empty", 64'(s_if.rd_empty), 64'h1);
        chk("drained valid", 64'(s_if.rd_valid), 64'h0);

        for (int i = 0; i < DEPTH; i++) step(1, 0, 64'(100 + i));
        step(1, 1, 64'hEE);
        chk("full wr+rd count", 64'(s_if.data_count), 64'd63);
        chk("full wr+rd ack", 64'(s_if.wr_ack), 64'h0);
        chk("full wr+rd data", s_if.rd_data, 64'd100);
        chk("full wr+rd fwft count", 64'(f_if.data_count), 64'd63);

        step(0, 0, 64'h0);
        rstn = 1'b0;
        step(0, 0, 64'h0);
        rstn = 1'b1;
        chk("midreset count", 64'(s_if.data_count), 64'h0);
        chk("midreset fwft empty", 64'(f_if.rd_empty), 64'h1);

        cyc = 0;
        while ((sent.size() < 200 || got.size() < 200) && cyc < 5000) begin
            logic [63:0] d;
            bit we, re;
            d = {$urandom, $urandom};
            we = sent.size() < 200 && $urandom_range(0, 99) < 55;
            re = $urandom_range(0, 99) < 50;
            if (we && s_if.wr_full == 1'b0) sent.push_back(d);
            step(we, re, d);
            if (s_if.rd_valid) got.push_back(s_if.rd_data);
            cyc++;
        end
        chk("wrap words out", 64'(got.size()), 64'(sent.size()));
        for (int i = 0; i < got.size() && i < sent.size(); i++)
            chk($sformatf("wrap word %0d", i), got[i], sent[i]);

        do_reset();
        step(1, 0, 64'hAA);
        chk("fwft edgeN valid", 64'(f_if.rd_valid), 64'h0);
        chk("fwft edgeN empty", 64'(f_if.rd_empty), 64'h1);
        step(0, 0, 64'h0);
        chk("fwft N+1 valid", 64'(f_if.rd_valid), 64'h1);
        chk("fwft N+1 data", f_if.rd_data, 64'hAA);
        step(0, 1, 64'h0);
        chk("fwft pop empty", 64'(f_if.rd_empty), 64'h1);
        chk("fwft pop data", f_if.rd_data, ZERO ? 64'h0 : 64'hAA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
